// File: rtl/udcnt_pkg.sv
// Shared encodings for the parametrised up/down counter.
package udcnt_pkg;

  localparam logic [1:0] UDCNT_MODE_WRAP   = 2'd0;
  localparam logic [1:0] UDCNT_MODE_SAT    = 2'd1;
  localparam logic [1:0] UDCNT_MODE_BOUNCE = 2'd2;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/udcnt_next_val.sv
// Combinational step logic: next count, next direction and boundary event flag.
module udcnt_next_val
  import udcnt_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] next_val_c,
  output logic             next_dir_c,
  output logic             event_c
);

  logic [WIDTH:0] cur_x;
  logic [WIDTH:0] lo_x;
  logic [WIDTH:0] hi_x;

  assign cur_x = {1'b0, cur};
  assign lo_x  = {1'b0, lo};
  assign hi_x  = {1'b0, hi};

  // Step one position in the effective direction; limits fold per mode.
  always_comb begin
    next_val_c = cur;
    next_dir_c = dir;
    event_c    = 1'b0;
    if (dir == DIR_UP) begin
      if (cur_x >= hi_x) begin
        event_c = 1'b1;
        case (mode)
          UDCNT_MODE_SAT:    next_val_c = hi;
          UDCNT_MODE_BOUNCE: begin
            next_val_c = WIDTH'(hi_x - (WIDTH+1)'(1));
            next_dir_c = DIR_DOWN;
          end
          default:           next_val_c = lo;
        endcase
      end else begin
        next_val_c = WIDTH'(cur_x + (WIDTH+1)'(1));
      end
    end else begin
      if (cur_x <= lo_x) begin
        event_c = 1'b1;
        case (mode)
          UDCNT_MODE_SAT:    next_val_c = lo;
          UDCNT_MODE_BOUNCE: begin
            next_val_c = WIDTH'(lo_x + (WIDTH+1)'(1));
            next_dir_c = DIR_UP;
          end
          default:           next_val_c = hi;
        endcase
      end else begin
        next_val_c = WIDTH'(cur_x - (WIDTH+1)'(1));
      end
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap/saturate/bounce limits and a registered TC pulse.
// Optional TC event counter enabled by defining UDCNT_EVENT_COUNT_EN.
module updown_counter_param
  import udcnt_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LO_LIMIT  = 0,
  parameter int unsigned HI_LIMIT  = 255,
  parameter int unsigned EVT_WIDTH = 16
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic                 CONTROL,
  input  logic [1:0]           MODE,
  input  logic                 LOAD,
  input  logic [WIDTH-1:0]     LOAD_VALUE,
  output logic [WIDTH-1:0]     OUT,
  output logic                 DIR,
  output logic                 TC,
  output logic [EVT_WIDTH-1:0] EVENTS
);

  if ((LO_LIMIT >= HI_LIMIT) || (64'(HI_LIMIT) >= (64'd1 << WIDTH))) begin : g_bad_limits
    $error("updown_counter_param: need LO_LIMIT < HI_LIMIT < 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] LO = WIDTH'(LO_LIMIT);
  localparam logic [WIDTH-1:0] HI = WIDTH'(HI_LIMIT);

  logic             eff_dir_c;
  logic [WIDTH-1:0] next_val_c;
  logic             next_dir_c;
  logic             evt_c;
  logic [WIDTH-1:0] load_clamp_c;

  // Bounce owns its direction; other modes follow CONTROL each step.
  assign eff_dir_c = (MODE == UDCNT_MODE_BOUNCE) ? DIR : CONTROL;

  assign load_clamp_c = (LOAD_VALUE < LO) ? LO :
                        (LOAD_VALUE > HI) ? HI : LOAD_VALUE;

  udcnt_next_val #(.WIDTH(WIDTH)) u_next (
    .cur        (OUT),
    .dir        (eff_dir_c),
    .mode       (MODE),
    .lo         (LO),
    .hi         (HI),
    .next_val_c (next_val_c),
    .next_dir_c (next_dir_c),
    .event_c    (evt_c)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      OUT <= LO;
      DIR <= DIR_UP;
      TC  <= 1'b0;
    end else if (LOAD) begin
      OUT <= load_clamp_c;
      DIR <= CONTROL;
      TC  <= 1'b0;
    end else if (ENABLE) begin
      OUT <= next_val_c;
      DIR <= next_dir_c;
      TC  <= evt_c;
    end else begin
      TC  <= 1'b0;
    end
  end

`ifdef UDCNT_EVENT_COUNT_EN
  logic [EVT_WIDTH-1:0] events_q;

  // Saturating count of TC events; cleared alongside the count on load.
  always_ff @(posedge CLOCK) begin
    if (RESET || LOAD) begin
      events_q <= '0;
    end else if (ENABLE && evt_c && (events_q != '1)) begin
      events_q <= events_q + EVT_WIDTH'(1);
    end
  end

  assign EVENTS = events_q;
`else
  assign EVENTS = '0;
`endif

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench for updown_counter_param (WIDTH=8, LO=3, HI=9).
module tb_updown_counter_param;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LO    = 3;
  localparam int unsigned HI    = 9;
  localparam int unsigned EW    = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             control = 1'b1;
  logic [1:0]       mode = 2'd0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic [WIDTH-1:0] out;
  logic             dir;
  logic             tc;
  logic [EW-1:0]    events;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state
  int m_out, m_dir, m_tc, m_evt;

  updown_counter_param #(
    .WIDTH(WIDTH), .LO_LIMIT(LO), .HI_LIMIT(HI), .EVT_WIDTH(EW)
  ) dut (
    .CLOCK(clk), .RESET(reset), .ENABLE(enable), .CONTROL(control),
    .MODE(mode), .LOAD(load), .LOAD_VALUE(load_value),
    .OUT(out), .DIR(dir), .TC(tc), .EVENTS(events)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs derived directly from the counting rules.
  always @(posedge clk) begin
    int d;
    int clamp;
    if (reset) begin
      m_out = LO; m_dir = 1; m_tc = 0; m_evt = 0;
    end else if (load) begin
      clamp = int'(load_value);
      if (clamp < int'(LO)) clamp = LO;
      if (clamp > int'(HI)) clamp = HI;
      m_out = clamp; m_dir = int'(control); m_tc = 0; m_evt = 0;
    end else if (enable) begin
      d = (mode == 2'd2) ? m_dir : int'(control);
      m_tc = 0;
      if (d == 1 && m_out == int'(HI)) begin
        m_tc = 1;
        if (mode == 2'd2) begin m_out = HI - 1; m_dir = 0; end
        else if (mode != 2'd1) m_out = LO;
      end else if (d == 0 && m_out == int'(LO)) begin
        m_tc = 1;
        if (mode == 2'd2) begin m_out = LO + 1; m_dir = 1; end
        else if (mode != 2'd1) m_out = HI;
      end else begin
        m_out = m_out + ((d == 1) ? 1 : -1);
      end
      if (mode != 2'd2) m_dir = int'(control);
      if (m_tc == 1 && m_evt < 65535) m_evt++;
    end else begin
      m_tc = 0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("model_out", 64'(out), 64'(m_out));
      check("model_dir", 64'(dir), 64'(m_dir));
      check("model_tc",  64'(tc),  64'(m_tc));
`ifdef UDCNT_EVENT_COUNT_EN
      check("model_events", 64'(events), 64'(m_evt));
`else
      check("model_events", 64'(events), 64'd0);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int v, input logic c);
    load = 1'b1; load_value = WIDTH'(v); control = c;
    edges(1);
    load = 1'b0;
  endtask

  initial begin
    int wrap_out[7];
    int wrap_tc[7];
    int tc_pulses;
    wrap_out = '{4, 5, 6, 7, 8, 9, 3};
    wrap_tc  = '{0, 0, 0, 0, 0, 0, 1};

    edges(2);
    chk_en = 1'b1;
    check("reset_out", 64'(out), 64'd3);
    check("reset_dir", 64'(dir), 64'd1);
    check("reset_tc",  64'(tc),  64'd0);
    check("reset_events", 64'(events), 64'd0);

    // Wrap up from reset
    reset = 1'b0; enable = 1'b1; control = 1'b1; mode = 2'd0;
    for (int i = 0; i < 7; i++) begin
      edges(1);
      check("wrap_up_out", 64'(out), 64'(wrap_out[i]));
      check("wrap_up_tc",  64'(tc),  64'(wrap_tc[i]));
    end
    edges(1);
    check("wrap_up_after_out", 64'(out), 64'd4);
    check("wrap_up_after_tc",  64'(tc),  64'd0);

    // Wrap down from LO
    do_load(3, 1'b1);
    check("load3_out", 64'(out), 64'd3);
    check("load3_tc",  64'(tc),  64'd0);
    control = 1'b0;
    edges(1);
    check("wrap_dn_out", 64'(out), 64'd9);
    check("wrap_dn_tc",  64'(tc),  64'd1);
    edges(1);
    check("wrap_dn_next_out", 64'(out), 64'd8);
    check("wrap_dn_next_tc",  64'(tc),  64'd0);

    // Saturate at HI then at LO
    mode = 2'd1;
    do_load(8, 1'b1);
    edges(1); check("sat_hi1_out", 64'(out), 64'd9); check("sat_hi1_tc", 64'(tc), 64'd0);
    edges(1); check("sat_hi2_out", 64'(out), 64'd9); check("sat_hi2_tc", 64'(tc), 64'd1);
    edges(1); check("sat_hi3_out", 64'(out), 64'd9); check("sat_hi3_tc", 64'(tc), 64'd1);
    do_load(4, 1'b0);
    edges(1); check("sat_lo1_out", 64'(out), 64'd3); check("sat_lo1_tc", 64'(tc), 64'd0);
    edges(1); check("sat_lo2_out", 64'(out), 64'd3); check("sat_lo2_tc", 64'(tc), 64'd1);
    edges(1); check("sat_lo3_out", 64'(out), 64'd3); check("sat_lo3_tc", 64'(tc), 64'd1);

    // Bounce with CONTROL scrambled: 3 up to 9, back to 3, up to 4
    do_load(3, 1'b1);
    mode = 2'd2;
    tc_pulses = 0;
    for (int i = 1; i <= 13; i++) begin
      control = 1'($urandom_range(0, 1));
      edges(1);
      if (tc === 1'b1) tc_pulses++;
      if (i == 7) begin
        check("bounce_hi_out", 64'(out), 64'd8);
        check("bounce_hi_dir", 64'(dir), 64'd0);
        check("bounce_hi_tc",  64'(tc),  64'd1);
      end
    end
    check("bounce_lo_out", 64'(out), 64'd4);
    check("bounce_lo_dir", 64'(dir), 64'd1);
    check("bounce_pulses", 64'(tc_pulses), 64'd2);

    // Load clamp and priority
    mode = 2'd0;
    do_load(200, 1'b1);
    check("clamp_hi_out", 64'(out), 64'd9);
    do_load(0, 1'b1);
    check("clamp_lo_out", 64'(out), 64'd3);
    enable = 1'b0;
    do_load(6, 1'b0);
    check("load_noen_out", 64'(out), 64'd6);
    check("load_noen_dir", 64'(dir), 64'd0);
    edges(2);
    check("hold_out", 64'(out), 64'd6);
    check("hold_tc",  64'(tc),  64'd0);
    reset = 1'b1; load = 1'b1; load_value = 8'd7; control = 1'b0;
    edges(1);
    reset = 1'b0; load = 1'b0;
    check("rst_load_out", 64'(out), 64'd3);
    check("rst_load_dir", 64'(dir), 64'd1);

    // Reserved mode wraps
    enable = 1'b1; mode = 2'd3;
    do_load(9, 1'b1);
    edges(1);
    check("mode3_out", 64'(out), 64'd3);
    check("mode3_tc",  64'(tc),  64'd1);

    // Event counter: five wraps from LO, then clear by load
    mode = 2'd0;
    do_load(3, 1'b1);
    edges(35);
    check("wrap5_out", 64'(out), 64'd3);
`ifdef UDCNT_EVENT_COUNT_EN
    check("events_5", 64'(events), 64'd5);
`else
    check("events_5", 64'(events), 64'd0);
`endif
    do_load(5, 1'b1);
    check("events_clear", 64'(events), 64'd0);
    edges(3);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
